// File: rtl/vga_rgb_fifo.sv
// RGB pixel FIFO between the colour processor and the video output stage, with early full and sticky ovf/unf.
// Define VGA_RGB_FIFO_FWFT_EN for first-word-fall-through read data; default is a registered read.
module vga_rgb_fifo #(
  parameter int AWIDTH     = 4,
  parameter int DWIDTH     = 24,
  parameter int FULL_SLACK = 1
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              sclr,
  input  logic              wreq,
  input  logic [DWIDTH-1:0] d,
  output logic              full,
  input  logic              rreq,
  output logic [DWIDTH-1:0] q,
  output logic              empty,
  output logic [AWIDTH:0]   nword,
  output logic              ovf,
  output logic              unf
);

  localparam int DEPTH = 2 ** AWIDTH;
  localparam logic [AWIDTH:0] DEPTH_N  = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH:0] FULL_LVL = (AWIDTH+1)'(DEPTH - FULL_SLACK);

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [AWIDTH:0]   nword_q, nword_d;
  logic              empty_q, full_q, ovf_q, unf_q;
  logic              ovf_d, unf_d;
  logic              rd_ok, we_ok;

  // A read freeing a slot lets a write land even when all DEPTH entries are in use.
  assign rd_ok = rreq & ~empty_q;
  assign we_ok = wreq & ((nword_q < DEPTH_N) | rd_ok);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    nword_d  = nword_q;
    if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    if (we_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    case ({we_ok, rd_ok})
      2'b10:   nword_d = nword_q + 1'b1;
      2'b01:   nword_d = nword_q - 1'b1;
      default: nword_d = nword_q;
    endcase
    ovf_d = ovf_q | (wreq & ~we_ok);
    unf_d = unf_q | (rreq & ~rd_ok);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      nword_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else if (sclr) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      nword_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      nword_q  <= nword_d;
      empty_q  <= (nword_d == '0);
      full_q   <= (nword_d >= FULL_LVL);
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we_ok && !sclr) mem_q[wr_ptr_q] <= d;
  end

`ifdef VGA_RGB_FIFO_FWFT_EN
  // Head word straight from the array; forced to zero while empty so reset/flush read back zero.
  assign q = empty_q ? '0 : mem_q[rd_ptr_q];
`else
  logic [DWIDTH-1:0] q_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)      q_q <= '0;
    else if (sclr)  q_q <= '0;
    else if (rd_ok) q_q <= mem_q[rd_ptr_q];
  end

  assign q = q_q;
`endif

  assign full  = full_q;
  assign empty = empty_q;
  assign nword = nword_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;

endmodule

// File: tb/tb_vga_rgb_fifo.sv
// Randomized bench for vga_rgb_fifo against a queue-based reference model of the FIFO rules.
module tb_vga_rgb_fifo;

  logic        clk = 1'b0;
  logic        nrst;
  logic        sclr;
  logic        wreq;
  logic [23:0] d;
  logic        full;
  logic        rreq;
  logic [23:0] q;
  logic        empty;
  logic [4:0]  nword;
  logic        ovf;
  logic        unf;

  int checks   = 0;
  int failures = 0;

  logic [23:0] m_fifo [$];
  logic [23:0] m_q;
  logic        m_ovf, m_unf;

  vga_rgb_fifo dut (
    .clk   (clk),
    .nrst  (nrst),
    .sclr  (sclr),
    .wreq  (wreq),
    .d     (d),
    .full  (full),
    .rreq  (rreq),
    .q     (q),
    .empty (empty),
    .nword (nword),
    .ovf   (ovf),
    .unf   (unf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_fifo.delete();
    m_q   = '0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // Spec-level behaviour: a read pops the head if anything is stored; a write is taken if a slot is free after that.
  task automatic model_step(input logic w, input logic r, input logic [23:0] dd, input logic c);
    logic rd, wr;
    if (c) begin
      model_clear();
      return;
    end
    rd = r && (m_fifo.size() > 0);
    wr = w && ((m_fifo.size() < 16) || rd);
    if (rd) m_q = m_fifo.pop_front();
    if (r && !rd) m_unf = 1'b1;
    if (w && !wr) m_ovf = 1'b1;
    if (wr) m_fifo.push_back(dd);
  endtask

  task automatic compare_all();
    check("nword", 32'(nword), 32'(m_fifo.size()));
    check("empty", 32'(empty), 32'(m_fifo.size() == 0));
    check("full",  32'(full),  32'(m_fifo.size() >= 15));
    check("ovf",   32'(ovf),   32'(m_ovf));
    check("unf",   32'(unf),   32'(m_unf));
`ifdef VGA_RGB_FIFO_FWFT_EN
    if (m_fifo.size() > 0) check("q_head", 32'(q), 32'(m_fifo[0]));
`else
    check("q", 32'(q), 32'(m_q));
`endif
  endtask

  task automatic cycle(input logic w, input logic r, input logic [23:0] dd, input logic c);
    wreq = w;
    rreq = r;
    d    = dd;
    sclr = c;
    @(posedge clk);
    model_step(w, r, dd, c);
    #1;
    compare_all();
    wreq = 1'b0;
    rreq = 1'b0;
    sclr = 1'b0;
  endtask

  initial begin
    nrst = 1'b0;
    sclr = 1'b0;
    wreq = 1'b0;
    rreq = 1'b0;
    d    = '0;
    model_clear();
    @(posedge clk);
    #1;
    compare_all();
    check("reset_q", 32'(q), 32'h0);
    nrst = 1'b1;

    // Five writes, then an asynchronous reset in the middle of a cycle.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 24'(i + 1), 1'b0);
    #2;
    nrst = 1'b0;
    #1;
    model_clear();
    compare_all();
    check("async_rst_q", 32'(q), 32'h0);
    @(posedge clk);
    #1;
    nrst = 1'b1;

    // Same with the synchronous flush; the read in the flush cycle must be ignored.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 24'(i + 8), 1'b0);
    cycle(1'b0, 1'b1, 24'h0, 1'b0);
    cycle(1'b1, 1'b1, 24'hABCDEF, 1'b1);
    check("sclr_q", 32'(q), 32'h0);

    // Fill to the top: full at 15, 16th accepted, 17th dropped.
    for (int i = 1; i <= 17; i++) cycle(1'b1, 1'b0, 24'(i), 1'b0);
    check("ovf_after_17", 32'(ovf), 32'h1);
    check("nword_cap", 32'(nword), 32'd16);
    cycle(1'b0, 1'b0, 24'h0, 1'b1);

    // Simultaneous read/write at 16 entries keeps the level and raises no overflow.
    for (int i = 1; i <= 16; i++) cycle(1'b1, 1'b0, 24'(i), 1'b0);
    cycle(1'b1, 1'b1, 24'h777777, 1'b0);
    check("both_at_full_ovf", 32'(ovf), 32'h0);
    check("both_at_full_nword", 32'(nword), 32'd16);
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 24'h0, 1'b0);

    // Simultaneous at empty: write taken, read rejected.
    cycle(1'b1, 1'b1, 24'h0000AA, 1'b0);
    check("both_at_empty_nword", 32'(nword), 32'd1);
    check("both_at_empty_unf", 32'(unf), 32'h1);
    cycle(1'b0, 1'b0, 24'h0, 1'b1);

    // Underflow holds the last read word.
    cycle(1'b1, 1'b0, 24'h123456, 1'b0);
    cycle(1'b0, 1'b1, 24'h0, 1'b0);
    cycle(1'b0, 1'b1, 24'h0, 1'b0);
`ifndef VGA_RGB_FIFO_FWFT_EN
    check("unf_q_hold", 32'(q), 32'h123456);
`endif
    cycle(1'b1, 1'b0, 24'h00BEEF, 1'b0);
    cycle(1'b0, 1'b1, 24'h0, 1'b0);
    cycle(1'b0, 1'b0, 24'h0, 1'b1);

    // 40 indexed words interleaved with random reads, crossing the pointer wrap.
    begin
      int widx = 0;
      while (widx < 40 || m_fifo.size() > 0) begin
        logic w, r;
        w = (widx < 40) && ($urandom_range(0, 99) < 55);
        r = $urandom_range(0, 99) < 45;
        cycle(w, r, 24'(widx), 1'b0);
        if (w) widx++;
      end
    end

    // Free-running random traffic with phases biased toward full and empty.
    for (int i = 0; i < 800; i++) begin
      int pw;
      logic w, r, c;
      pw = ((i / 100) % 2 == 0) ? 75 : 25;
      w  = $urandom_range(0, 99) < pw;
      r  = $urandom_range(0, 99) < (100 - pw);
      c  = $urandom_range(0, 199) == 0;
      cycle(w, r, 24'($urandom), c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_rgb_fifo.md
Name: vga_rgb_fifo

Overview:
- Synchronous FIFO between the colour processor and the pixel output / timing stage.
- Accepts one 24-bit RGB pixel per write request and delivers pixels in order to the video output stage on read requests.
- The colour processor registers its write request one cycle after sampling `full`, so `full` asserts one entry early. That in-flight write is never lost.
- Sticky overflow/underflow flags report rate problems to the status register.

Parameters:
- AWIDTH, 4: address width; DEPTH = 2**AWIDTH entries (16).
- DWIDTH, 24: data width; packed {R[7:0], G[7:0], B[7:0]}.
- FULL_SLACK, 1: number of entries reserved for writes already in flight when `full` asserts.

Ports:
- clk    in   1           master clock, rising edge
- nrst   in   1           asynchronous active-low reset
- sclr   in   1           synchronous clear (flush), active high
- wreq   in   1           write request; `d` valid in same cycle
- d      in   DWIDTH      write data {R,G,B}
- full   out  1           no further writes may be issued
- rreq   in   1           read request (pop)
- q      out  DWIDTH      read data
- empty  out  1           no entries stored
- nword  out  AWIDTH+1    current fill level, 0..DEPTH
- ovf    out  1           sticky: a write was dropped
- unf    out  1           sticky: a read was attempted while empty

Behaviour:
- Reset (nrst=0, asynchronous):
  - rd_ptr=0, wr_ptr=0, nword=0, empty=1, full=0, ovf=0, unf=0, q=0.
  - Storage array is not reset.
- sclr=1 (synchronous, highest priority after nrst): same values as reset, including q=0 and flags cleared. Any wreq/rreq in that cycle is ignored.
- Storage: DEPTH x DWIDTH register or RAM array, written on clk.
- Write accept: we_ok = wreq & ((nword < DEPTH) | rd_ok).
  - On we_ok: mem[wr_ptr] <= d; wr_ptr <= wr_ptr+1, wrapping modulo DEPTH.
- Read accept: rd_ok = rreq & ~empty.
  - On rd_ok: rd_ptr <= rd_ptr+1, wrapping modulo DEPTH.
- Fill level:
  - nword += 1 on write-only, -= 1 on read-only, unchanged on both or neither.
  - nword is registered and never exceeds DEPTH or goes below 0.
- Flags, all registered from the next-state nword:
  - empty = (nword == 0)
  - full  = (nword >= DEPTH - FULL_SLACK); with defaults, full is asserted at 15 and 16 entries.
- Simultaneous read and write:
  - At nword = DEPTH: both are accepted; nword stays DEPTH.
  - At nword = 0 (non-FWFT mode): the read is rejected (unf set) and the write is accepted; nword becomes 1.
- Overflow: wreq with nword = DEPTH and no accepted read → data dropped, pointers unchanged, ovf <= 1 (sticky until nrst/sclr).
- Underflow: rreq while empty=1 → no pointer change, q holds its previous value, unf <= 1 (sticky).
- Read data, default mode (macro undefined):
  - q <= mem[rd_ptr] on rd_ok.
  - Latency: q is valid one cycle after an accepted rreq and holds until the next accepted read.
- Pointer wrap: pointers are AWIDTH bits and wrap DEPTH-1 → 0 with no gap; ordering is preserved across the wrap.
- No combinational path from wreq/rreq to any output.

Optional Feature:
- Macro: VGA_RGB_FIFO_FWFT_EN
- Defined (first-word-fall-through):
  - q = mem[rd_ptr] combinationally from the array whenever empty=0; the head word is visible with zero latency.
  - rreq acknowledges and pops; q shows the next word in the following cycle.
  - q is don't-care while empty=1.
  - A write into an empty FIFO appears on q the cycle after the write edge, when empty falls.
- Undefined: registered read as described under Behaviour (1-cycle latency, q holds).
- Flags, nword and overflow/underflow behaviour are identical in both modes.

Test Plan:
- Reset/flush:
  - Write 5 words, then assert nrst low mid-cycle → immediately empty=1, nword=0, full=0, q=0.
  - Repeat using sclr; the rreq issued in the sclr cycle is ignored.
- Fill and full timing: write 0x000001..0x000010 with no reads.
  - full rises when nword=15.
  - A 16th write issued while full=1 is accepted (nword=16).
  - A 17th write sets ovf=1 and nword stays 16.
- Order and wrap: 40 interleaved writes and reads with random gaps, data = index.
  - q sequence equals 0..39 in order across pointer wrap.
  - Default mode: each q arrives one cycle after its rreq.
- Simultaneous at boundaries:
  - At nword=16, wreq+rreq → both accepted, nword=16, ovf stays 0.
  - At nword=0, wreq+rreq → nword=1, unf=1 (non-FWFT).
- Underflow: rreq on an empty FIFO with q=0x123456 → q holds 0x123456, unf=1, pointers unchanged.
- FWFT build (VGA_RGB_FIFO_FWFT_EN): write 0xFF0000 into an empty FIFO.
  - Next cycle empty=0 and q=0xFF0000 without rreq.
  - rreq → empty=1 the following cycle.
